// File: rtl/dispensador_billetes.sv
// Cash dispenser sequencer: validates a requested amount, then drives the bill
// mechanism one bill at a time (largest denomination first) with an ack handshake and jam watchdog.
module dispensador_billetes #(
  parameter int unsigned TIMEOUT   = 100,
  parameter int unsigned MONTO_MAX = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entregar_dinero,
  input  logic [31:0] monto,
  input  logic        billete_ack,
  output logic        billete_stb,
  output logic [2:0]  denominacion,
  output logic        ocupado,
  output logic        entrega_completa,
  output logic        monto_invalido,
  output logic        atasco,
  output logic [7:0]  billetes_entregados
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, SELECT, DISPENSE, DONE, ERROR
  } state_t;

  state_t            state, state_next;
  logic [31:0]       restante;
  logic [CNT_W-1:0]  wait_cnt;
  logic              monto_ok;
  logic              timeout_hit;
  logic [2:0]        denom_sel;

  function automatic logic [31:0] valor_billete(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'd20000;
      3'd1:    return 32'd10000;
      3'd2:    return 32'd5000;
      3'd3:    return 32'd2000;
      default: return 32'd1000;
    endcase
  endfunction

  assign monto_ok    = (restante != 32'd0) && (restante <= 32'(MONTO_MAX))
                       && ((restante % 32'd1000) == 32'd0);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Greedy choice; restante is a nonzero multiple of 1000 whenever this is used.
  always_comb begin
    if      (restante >= 32'd20000) denom_sel = 3'd0;
    else if (restante >= 32'd10000) denom_sel = 3'd1;
    else if (restante >= 32'd5000)  denom_sel = 3'd2;
    else if (restante >= 32'd2000)  denom_sel = 3'd3;
    else                            denom_sel = 3'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: next state defaults to the current state before the case, so no path
  // leaves state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (entregar_dinero) state_next = CHECK;
      CHECK:    state_next = monto_ok ? SELECT : IDLE;
      SELECT:   state_next = (restante == 32'd0) ? DONE : DISPENSE;
      DISPENSE: begin
        if (billete_ack)      state_next = SELECT;
        else if (timeout_hit) state_next = ERROR;
      end
      DONE:     state_next = IDLE;
      ERROR:    state_next = ERROR;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      restante            <= '0;
      wait_cnt            <= '0;
      denominacion        <= '0;
      monto_invalido      <= 1'b0;
      billetes_entregados <= '0;
    end else begin
      monto_invalido <= (state == CHECK) && !monto_ok;
      case (state)
        IDLE: begin
          if (entregar_dinero) begin
            restante            <= monto;
            billetes_entregados <= '0;
          end
        end
        SELECT: begin
          wait_cnt <= '0;
          if (restante != 32'd0) denominacion <= denom_sel;
        end
        DISPENSE: begin
          if (billete_ack) begin
            restante <= restante - valor_billete(denominacion);
            if (billetes_entregados != 8'hFF)
              billetes_entregados <= billetes_entregados + 8'd1;
          end else if (!timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them without a clock.
  assign billete_stb      = (state == DISPENSE);
  assign ocupado          = (state != IDLE);
  assign entrega_completa = (state == DONE);
  assign atasco           = (state == ERROR);

endmodule

// File: tb/tb_dispensador_billetes.sv
// Self-checking bench for dispensador_billetes: directed table, corner sequences
// (jam, ignored start, async reset) and random amounts against a greedy-change model.
module tb_dispensador_billetes;

  localparam int unsigned TIMEOUT   = 100;
  localparam int unsigned MONTO_MAX = 500000;

  logic        clk = 1'b0;
  logic        rst;
  logic        entregar_dinero;
  logic [31:0] monto;
  logic        billete_ack;
  logic        billete_stb;
  logic [2:0]  denominacion;
  logic        ocupado;
  logic        entrega_completa;
  logic        monto_invalido;
  logic        atasco;
  logic [7:0]  billetes_entregados;

  int checks = 0;
  int errors = 0;

  int unsigned exp_q[$];
  int unsigned got_q[$];

  typedef struct {
    int unsigned monto;
    bit          valido;
    int unsigned billetes;
    int unsigned primera;
  } vec_t;

  vec_t tab[10];

  dispensador_billetes #(.TIMEOUT(TIMEOUT), .MONTO_MAX(MONTO_MAX)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .entregar_dinero     (entregar_dinero),
    .monto               (monto),
    .billete_ack         (billete_ack),
    .billete_stb         (billete_stb),
    .denominacion        (denominacion),
    .ocupado             (ocupado),
    .entrega_completa    (entrega_completa),
    .monto_invalido      (monto_invalido),
    .atasco              (atasco),
    .billetes_entregados (billetes_entregados)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: valid amounts are broken into bills greedily by integer division.
  function automatic bit model(input int unsigned m);
    int unsigned valores[5] = '{20000, 10000, 5000, 2000, 1000};
    int unsigned rem;
    exp_q.delete();
    if (m == 0 || m > MONTO_MAX || (m % 1000) != 0) return 1'b0;
    rem = m;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < int'(rem / valores[i]); j++) exp_q.push_back(i);
      rem = rem % valores[i];
    end
    return 1'b1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_stb"},      32'(billete_stb), 32'd0);
    check({tag, "_denom"},    32'(denominacion), 32'd0);
    check({tag, "_ocupado"},  32'(ocupado), 32'd0);
    check({tag, "_completa"}, 32'(entrega_completa), 32'd0);
    check({tag, "_invalido"}, 32'(monto_invalido), 32'd0);
    check({tag, "_atasco"},   32'(atasco), 32'd0);
    check({tag, "_billetes"}, 32'(billetes_entregados), 32'd0);
  endtask

  // Runs one transaction with a random ack delay per bill; inject_at>0 pulses a
  // second start (monto=1000) at that cycle, which the DUT must ignore.
  task automatic run_txn(input int unsigned m, input int inject_at,
                         output bit got_valid, output int unsigned got_bills,
                         output int unsigned got_first);
    bit          exp_valid;
    bit          done, inv, prev_stb;
    int          k, first_stb, waited, delay;
    logic [2:0]  denom_hold;
    exp_valid = model(m);
    got_q.delete();
    @(negedge clk);
    entregar_dinero = 1'b1;
    monto = m;
    k = 0; done = 0; inv = 0; prev_stb = 0; first_stb = -1; waited = 0;
    delay = $urandom_range(0, 3);
    denom_hold = '0;
    got_bills = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
      entregar_dinero = (k == inject_at);
      monto = (k == inject_at) ? 32'd1000 : m;
      billete_ack = 1'b0;
      if (k == 1) begin
        check("start_ocupado", 32'(ocupado), 32'd1);
        check("start_clear_count", 32'(billetes_entregados), 32'd0);
      end
      if (monto_invalido) begin
        inv = 1; done = 1;
        check("invalid_latency", 32'(k), 32'd2);
      end else if (entrega_completa) begin
        done = 1;
        got_bills = billetes_entregados;
      end else if (billete_stb) begin
        if (!prev_stb) begin
          if (first_stb < 0) first_stb = k;
          denom_hold = denominacion;
          waited = 0;
        end
        check("denom_stable", 32'(denominacion), 32'(denom_hold));
        if (waited == delay) begin
          billete_ack = 1'b1;
          got_q.push_back(denominacion);
          delay = $urandom_range(0, 3);
        end else begin
          waited++;
        end
      end
      prev_stb = billete_stb;
    end
    entregar_dinero = 1'b0;
    billete_ack = 1'b0;
    if (!done) check("txn_budget_expired", 32'd0, 32'd1);
    got_valid = done && !inv;
    got_first = (got_q.size() > 0) ? got_q[0] : 0;
    check("valid_vs_model", 32'(got_valid), 32'(exp_valid));
    if (inv) begin
      check("invalid_no_stb", 32'(first_stb), 32'hFFFF_FFFF);
      check("invalid_ocupado", 32'(ocupado), 32'd0);
      @(negedge clk);
      check("invalid_one_cycle", 32'(monto_invalido), 32'd0);
    end else if (done) begin
      check("first_stb_latency", 32'(first_stb), 32'd3);
      check("bills_vs_model", got_bills, 32'(exp_q.size()));
      check("seq_len_vs_model", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check("seq_denom_vs_model", got_q[i], exp_q[i]);
      @(negedge clk);
      check("completa_one_cycle", 32'(entrega_completa), 32'd0);
      check("idle_ocupado", 32'(ocupado), 32'd0);
      @(negedge clk);
      check("count_held_idle", 32'(billetes_entregados), got_bills);
    end
  endtask

  initial begin
    bit          v;
    int unsigned n, f, stb_cycles;
    int unsigned m;

    tab[0] = '{38000,  1'b1, 5,  0};
    tab[1] = '{1500,   1'b0, 0,  0};
    tab[2] = '{0,      1'b0, 0,  0};
    tab[3] = '{600000, 1'b0, 0,  0};
    tab[4] = '{500000, 1'b1, 25, 0};
    tab[5] = '{500001, 1'b0, 0,  0};
    tab[6] = '{1000,   1'b1, 1,  4};
    tab[7] = '{3000,   1'b1, 2,  3};
    tab[8] = '{9000,   1'b1, 3,  2};
    tab[9] = '{501000, 1'b0, 0,  0};

    rst = 1'b0;
    entregar_dinero = 1'b0;
    monto = '0;
    billete_ack = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_txn(tab[i].monto, -1, v, n, f);
      check("tab_valido", 32'(v), 32'(tab[i].valido));
      if (tab[i].valido) begin
        check("tab_billetes", n, tab[i].billetes);
        check("tab_primera", f, tab[i].primera);
      end
    end

    // 38000 must walk through every denomination in order.
    void'(model(38000));
    run_txn(38000, -1, v, n, f);
    check("seq_38000_len", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < got_q.size() && i < 5; i++)
      check("seq_38000_denom", got_q[i], 32'(i));

    // Start during dispensing is ignored.
    run_txn(40000, 5, v, n, f);
    check("ignore_start_bills", n, 32'd2);
    check("ignore_start_denom", f, 32'd0);

    // Jam: ack withheld.
    @(negedge clk);
    entregar_dinero = 1'b1;
    monto = 32'd20000;
    @(negedge clk);
    entregar_dinero = 1'b0;
    stb_cycles = 0;
    for (int k = 0; k < int'(TIMEOUT) + 50 && !atasco; k++) begin
      @(negedge clk);
      if (billete_stb) stb_cycles++;
    end
    check("jam_atasco", 32'(atasco), 32'd1);
    check("jam_stb_cycles", stb_cycles, TIMEOUT);
    check("jam_stb_low", 32'(billete_stb), 32'd0);
    check("jam_ocupado", 32'(ocupado), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      entregar_dinero = k[0];
      monto = 32'd1000;
      billete_ack = ~k[0];
    end
    @(negedge clk);
    entregar_dinero = 1'b0;
    billete_ack = 1'b0;
    @(negedge clk);
    check("jam_sticky", 32'(atasco), 32'd1);
    check("jam_no_count", 32'(billetes_entregados), 32'd0);
    check("jam_stb_still_low", 32'(billete_stb), 32'd0);
    #2 rst = 1'b0;
    #1 check_all_zero("jam_reset");
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset while a bill is being requested.
    @(negedge clk);
    entregar_dinero = 1'b1;
    monto = 32'd40000;
    @(negedge clk);
    entregar_dinero = 1'b0;
    for (int k = 0; k < 10 && !billete_stb; k++) @(negedge clk);
    check("areset_stb_before", 32'(billete_stb), 32'd1);
    billete_ack = 1'b1;
    #2 rst = 1'b0;
    #1 check_all_zero("areset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("areset_ack_ignored", 32'(billetes_entregados), 32'd0);
    check("areset_idle", 32'(ocupado), 32'd0);
    billete_ack = 1'b0;

    // Random amounts against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) m = $urandom_range(1, MONTO_MAX / 1000) * 1000;
      else                           m = $urandom_range(0, 700000);
      run_txn(m, ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 12)) : -1, v, n, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispensador_billetes.md
DISPENSADOR_BILLETES -- requirements
Module: dispensador_billetes

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 100, as the max cycles billete_stb waits for billete_ack before declaring a jam.
REQ-002 The block SHALL take parameter MONTO_MAX, default 500000, as the largest amount dispensable in one transaction.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 entregar_dinero  in  1  one-cycle start pulse from the ATM controller.
REQ-007 monto  in  32  amount to dispense, unsigned, sampled with entregar_dinero.
REQ-008 billete_ack  in  1  dispenser mechanism confirms one bill delivered.
REQ-009 billete_stb  out  1  request to dispense one bill of type denominacion.
REQ-010 denominacion  out  3  bill index: 0=20000, 1=10000, 2=5000, 3=2000, 4=1000.
REQ-011 ocupado  out  1  high while a transaction is in progress.
REQ-012 entrega_completa  out  1  one-cycle pulse when the full amount is delivered.
REQ-013 monto_invalido  out  1  one-cycle pulse when the amount is rejected.
REQ-014 atasco  out  1  sticky jam flag.
REQ-015 billetes_entregados  out  8  bills delivered in the current transaction.

Function
REQ-016 The FSM SHALL have states IDLE, CHECK, SELECT, DISPENSE, DONE, ERROR.
REQ-017 In IDLE, entregar_dinero=1 at a clock edge SHALL latch monto into a 32-bit restante register, clear billetes_entregados and move to CHECK.
REQ-018 In CHECK, the FSM SHALL reject (monto_invalido pulse, next state IDLE) if restante==0, restante>MONTO_MAX, or restante mod 1000 != 0; otherwise it SHALL move to SELECT.
REQ-019 In SELECT, restante==0 SHALL move the FSM to DONE; otherwise denominacion SHALL be registered as the largest bill <= restante and the FSM SHALL move to DISPENSE.
REQ-020 billete_stb SHALL equal (state==DISPENSE); denominacion SHALL stay stable while billete_stb is high.
REQ-021 In DISPENSE, billete_ack=1 at an edge SHALL subtract the selected bill value from restante, increment billetes_entregados (saturating at 255) and return to SELECT.
REQ-022 In DISPENSE, a wait counter SHALL clear on entry and increment each cycle. If the counter reaches TIMEOUT with no ack, the FSM SHALL move to ERROR.
REQ-023 In DONE, entrega_completa SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-024 In ERROR, atasco SHALL be 1 and billete_stb 0, and the FSM SHALL remain in ERROR until rst is asserted.
REQ-025 ocupado SHALL be 1 in CHECK, SELECT, DISPENSE, DONE and ERROR, and 0 in IDLE.
REQ-026 entregar_dinero outside IDLE SHALL be ignored; billete_ack outside DISPENSE SHALL be ignored.
REQ-027 Latency: start sampled at edge e0 SHALL give billete_stb high after edge e2; after each ack, the next billete_stb SHALL rise 2 edges later.
REQ-028 billetes_entregados SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE and clear restante, the wait counter, denominacion, billete_stb, ocupado, entrega_completa, monto_invalido, atasco and billetes_entregados to 0.
REQ-030 Reset asserted mid-DISPENSE SHALL drop billete_stb without waiting for a clock edge; no ack SHALL be counted afterwards.

Verification
REQ-031 monto=38000, ack 1 cycle after each stb -> denominacion sequence 0,1,2,3,4, billetes_entregados=5, then one entrega_completa pulse, ocupado=0.
REQ-032 monto=1500 -> monto_invalido pulse 2 cycles after start, no billete_stb; monto=0 -> the same.
REQ-033 monto=600000 -> monto_invalido pulse; monto=500000 -> 25 bills of denominacion 0.
REQ-034 monto=20000, ack withheld -> atasco=1 after TIMEOUT cycles of stb, billete_stb=0, state held until rst pulse clears all.
REQ-035 entregar_dinero with monto=1000 while dispensing 40000 -> ignored, exactly 2 bills of 20000 delivered.
REQ-036 rst=0 asynchronously while billete_stb=1 -> all outputs 0 before the next clock edge.
